// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial pattern detector channels.
package seq_det_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StFilling = 2'd1,
        StArmed   = 2'd2
    } state_t;

    localparam int unsigned PATTERN_W_DEF = 8;
    localparam int unsigned LEN_W         = $clog2(PATTERN_W_DEF + 1);
    localparam logic [PATTERN_W_DEF-1:0] DEF_PATTERN = 8'b0001_0110;
    localparam int unsigned DEF_LEN       = 5;

endpackage

// File: rtl/seq_det_match_counter.sv
// Saturating match counter; a clear coinciding with an increment yields 1.
module seq_det_match_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= inc ? CNT_W'(1) : '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_pattern_detector.sv
// Run-time programmable serial pattern detector with registered match strobe
// and saturating match counter.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int unsigned           PATTERN_W       = PATTERN_W_DEF,
    parameter logic [PATTERN_W-1:0]  DEFAULT_PATTERN = DEF_PATTERN,
    parameter int unsigned           DEFAULT_LEN     = DEF_LEN,
    parameter bit                    DEFAULT_OVERLAP = 1'b1,
    parameter int unsigned           CNT_W           = 8
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           seq,
    input  logic                           valid,
    input  logic                           cfg_load,
    input  logic [PATTERN_W-1:0]           cfg_pattern,
    input  logic [$clog2(PATTERN_W+1)-1:0] cfg_len,
    input  logic                           cfg_overlap,
    input  logic                           cnt_clear,
    output logic                           detected,
    output logic [CNT_W-1:0]               match_count,
    output logic                           cfg_err
);

    localparam int unsigned LW = $clog2(PATTERN_W + 1);

    state_t               state;
    logic [PATTERN_W-1:0] history;
    logic [PATTERN_W-1:0] pattern_q;
    logic [LW-1:0]        len_q;
    logic [LW-1:0]        fill;
    logic                 overlap_q;

    logic [PATTERN_W-1:0] hist_n;
    logic [PATTERN_W-1:0] mask;
    logic [LW-1:0]        fill_n;
    logic                 armed_n;
    logic                 match;
    logic                 len_bad;

    // Next history/fill for a beat, and compare over the active length only.
    always_comb begin
        hist_n  = {history[PATTERN_W-2:0], seq};
        fill_n  = (fill < len_q) ? fill + LW'(1) : len_q;
        mask    = '0;
        for (int unsigned i = 0; i < PATTERN_W; i++) begin
            mask[i] = (LW'(i) < len_q);
        end
        armed_n = (state == StArmed) || (fill_n == len_q);
        match   = valid && !cfg_load && armed_n &&
                  (((hist_n ^ pattern_q) & mask) == '0);
        len_bad = (cfg_len == '0) || (32'(cfg_len) > PATTERN_W);
    end

    // Config, history and FSM; a beat in the cfg_load cycle is dropped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= StIdle;
            history   <= '0;
            fill      <= '0;
            pattern_q <= DEFAULT_PATTERN;
            len_q     <= LW'(DEFAULT_LEN);
            overlap_q <= DEFAULT_OVERLAP;
            cfg_err   <= 1'b0;
            detected  <= 1'b0;
        end else begin
            detected <= match;
            if (cfg_load) begin
                pattern_q <= cfg_pattern;
                len_q     <= len_bad ? LW'(PATTERN_W) : cfg_len;
                cfg_err   <= len_bad;
                overlap_q <= cfg_overlap;
                history   <= '0;
                fill      <= '0;
                state     <= StIdle;
            end else if (valid) begin
                history <= hist_n;
                if (match && !overlap_q) begin
                    // Restart: old history bits stay but are masked by fill.
                    fill  <= '0;
                    state <= StIdle;
                end else begin
                    fill  <= fill_n;
                    state <= (fill_n == len_q) ? StArmed : StFilling;
                end
            end
        end
    end

    seq_det_match_counter #(
        .CNT_W (CNT_W)
    ) u_match_counter (
        .clk    (clk),
        .resetn (resetn),
        .inc    (match),
        .clear  (cnt_clear),
        .count  (match_count)
    );

endmodule

// File: doc/seq_pattern_detector.md
Name: seq_pattern_detector

Overview:
Parametrised, run-time programmable serial pattern detector for the CORDIC control path. It replaces the fixed 5-bit "10110" Mealy detector with a configurable pattern, pattern length and overlap mode. It adds a registered match strobe and a saturating match counter, and sits between the serial command decoder and the CORDIC sequencer.

Parameters:
PATTERN_W, 8, maximum pattern length in bits (>=2)
DEFAULT_PATTERN, 8'b0001_0110, pattern loaded at reset (LSB-aligned)
DEFAULT_LEN, 5, active pattern length loaded at reset (1..PATTERN_W)
DEFAULT_OVERLAP, 1, overlap mode loaded at reset
CNT_W, 8, match counter width

Ports:
clk  in  1  clock
resetn  in  1  reset, asynchronous, active-low
seq  in  1  serial data bit
valid  in  1  seq qualifier; a beat occurs only when valid=1
cfg_load  in  1  single-cycle strobe: latch cfg_* and flush history
cfg_pattern  in  PATTERN_W  pattern; bit [len-1] is received first, bit [0] last
cfg_len  in  $clog2(PATTERN_W+1)  active pattern length
cfg_overlap  in  1  1 = overlapping matches allowed; 0 = restart after each match
cnt_clear  in  1  synchronous clear of match_count
detected  out  1  one-cycle match pulse, registered
match_count  out  CNT_W  saturating number of matches
cfg_err  out  1  high while the active config came from an invalid cfg_len

Behaviour:
- Reset values: detected=0; match_count=0; cfg_err=0; history=0; FSM=StIdle.
- Reset values: active pattern, len and overlap = DEFAULT_*.
- Reset asserted mid-stream discards all partial history. The first post-reset beat is treated as bit 1 of a new pattern.
- History: PATTERN_W-bit shift register. On each beat: history <= {history[PATTERN_W-2:0], seq}.
- Fill counter: saturates at active len.
- Compare: history[len-1:0] == pattern[len-1:0]. Bits at and above len are ignored.
- FSM, from package enum: StIdle (fill=0), StFilling (0<fill<len), StArmed (fill>=len).
- StIdle -> StFilling on a beat. If len=1, go directly to StArmed and evaluate the compare on that beat.
- StFilling -> StArmed on the beat that makes fill==len. The compare is evaluated on that beat.
- StArmed: compare on every beat.
- On a match with overlap=1: stay in StArmed.
- On a match with overlap=0: clear fill and go to StIdle. History bits are retained but masked by fill.
- No beat (valid=0): state, history and fill hold; detected=0 next cycle.
- Latency: detected rises exactly one clk after the rising edge that sampled the completing beat. This is a registered output, unlike the legacy combinational Mealy output.
- With the default config, detection follows the legacy "10110" overlapping sequence, shifted one cycle later.
- match_count increments on each match and saturates at all-ones.
- cnt_clear alone -> 0.
- cnt_clear together with a match in the same cycle -> 1; the match is never lost.
- cfg_load: latches cfg_pattern/cfg_len/cfg_overlap, clears history/fill, FSM -> StIdle.
- A valid beat in the cfg_load cycle is dropped.
- match_count is not affected by cfg_load.
- Invalid cfg_len (0 or >PATTERN_W): len is latched as PATTERN_W and cfg_err=1.
- cfg_err stays high until the next cfg_load with a valid length.
- cfg_load during a cycle that registers detected does not cancel that pulse.

Decomposition:
- Package seq_det_pkg: state enum (StIdle, StFilling, StArmed), localparam LEN_W = $clog2(PATTERN_W+1), default-pattern constant.
- Sub-module seq_det_match_counter: CNT_W saturating counter with inc/clear and clear+inc priority rule. Reused by other detector channels.

Test Plan:
- Default config, beats 1,0,1,1,0,1,1,0 -> detected pulses one cycle after beats 5 and 8; match_count=2.
- Same stream after cfg_load with pattern 10110, len 5, overlap 0 -> single pulse after beat 5; match_count +1.
- valid toggling 1/0 between every bit of "10110" -> still one pulse, one cycle after the final valid beat; idle cycles produce no pulse.
- cfg_load with len=0 -> cfg_err=1, len=8; pattern 8'hA5 detected after 8 beats; next valid load clears cfg_err.
- CNT_W=4 instance, 17 matches -> match_count stops at 15.
- cnt_clear in the same cycle as a match -> match_count=1.
- resetn pulsed after beats 1,0,1,1, then beat 0 -> no detect; full "10110" afterwards -> detect.
